// File: rtl/mem_table_scan_pkg.sv
// mem_table_scan_pkg
//   Shared definitions for the table scanner.
//   - Scanner FSM state encoding.
//   - Default word, address, count and index widths.
//   - Byte-address bases of the routing tables in the data memory.
package mem_table_scan_pkg;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MAX_COUNT  = 64;
  localparam int DEF_IDX_WIDTH  = 6;

  localparam logic [15:0] MAP_KNOWN_SINKS         = 16'h0008;
  localparam logic [15:0] MAP_WORST_HOPS          = 16'h0028;
  localparam logic [15:0] MAP_BATTERY_STAT        = 16'h0148;
  localparam logic [15:0] MAP_Q_VALUE             = 16'h01C8;
  localparam logic [15:0] MAP_KNOWN_SINK_COUNT    = 16'h0688;
  localparam logic [15:0] MAP_BETTER_NEIGHBOR_CNT = 16'h068C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_CNT = 3'd1,
    ST_SCAN   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_table_scan_if.sv
// mem_table_scan_if
//   Data-memory bus between the scanner and the memory.
//   mem_address : byte address (big-endian 16-bit words)
//   mem_wr_en   : write strobe, memory writes on posedge
//   mem_wdata   : write data
//   mem_rdata   : combinational read data for mem_address
//   Modports: master = scanner side, slave = memory side.
interface mem_table_scan_if
  import mem_table_scan_pkg::*;
#(
  parameter int AW = DEF_ADDR_WIDTH,
  parameter int DW = DEF_WORD_WIDTH
);

  logic [AW-1:0] mem_address;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_address,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_address,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_scan_cmp.sv
// mem_scan_cmp
//   Running best-entry tracker for the table scan.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     clear_i        : force best index/value to 0 (empty table)
//     sample_i       : an entry is presented this cycle
//     first_i        : presented entry is entry 0 (always taken)
//     find_min_i     : 0 = keep maximum, 1 = keep minimum
//     index_i        : index of presented entry
//     data_i         : value of presented entry
//     best_index_o   : index of current winner
//     best_value_o   : value of current winner
module mem_scan_cmp
  import mem_table_scan_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  sample_i,
  input  logic                  first_i,
  input  logic                  find_min_i,
  input  logic [IDX_WIDTH-1:0]  index_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic [IDX_WIDTH-1:0]  best_index_o,
  output logic [WORD_WIDTH-1:0] best_value_o
);

  logic [IDX_WIDTH-1:0]  best_index_q, best_index_d;
  logic [WORD_WIDTH-1:0] best_value_q, best_value_d;
  logic                  win;

  // Strict unsigned compare: an equal value never displaces the
  // earlier (lower-index) winner.
  always_comb begin
    win          = find_min_i ? (data_i < best_value_q) : (data_i > best_value_q);
    best_index_d = best_index_q;
    best_value_d = best_value_q;
    if (clear_i) begin
      best_index_d = '0;
      best_value_d = '0;
    end else if (sample_i && (first_i || win)) begin
      best_index_d = index_i;
      best_value_d = data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      best_index_q <= '0;
      best_value_q <= '0;
    end else begin
      best_index_q <= best_index_d;
      best_value_q <= best_value_d;
    end
  end

  assign best_index_o = best_index_q;
  assign best_value_o = best_value_q;

endmodule

// File: rtl/mem_table_scan.sv
// mem_table_scan
//   Bus initiator that reads a count word, walks a 16-bit word table and
//   reports the index/value of its maximum (or minimum) entry.
//   Optional feature macro: SCAN_WRITEBACK_EN -- adds a WRITE state that
//   stores the winning index to dest_addr_i.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     start_i        : request a scan (sampled in IDLE only)
//     find_min_i     : 0 = max, 1 = min (latched at start)
//     base_addr_i    : byte address of entry 0 (latched at start)
//     count_addr_i   : byte address of the count word (latched at start)
//     dest_addr_i    : writeback address (latched at start, writeback only)
//     mem            : memory bus, master side
//     busy_o         : high in every non-IDLE state
//     done_o         : one-cycle pulse with the final result
//     valid_o        : result covers at least one entry
//     best_index_o   : index of the winning entry
//     best_value_o   : value of the winning entry
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_IDLE   | waiting for start, bus parked at address 0
//   ST_RD_CNT | reading and clamping the entry count
//   ST_SCAN   | one table entry compared per cycle
//   ST_WRITE  | writing the winning index (writeback builds only)
//   ST_DONE   | done pulse, back to idle
module mem_table_scan
  import mem_table_scan_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_COUNT  = DEF_MAX_COUNT,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  find_min_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] count_addr_i,
  input  logic [ADDR_WIDTH-1:0] dest_addr_i,
  mem_table_scan_if.master      mem,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  valid_o,
  output logic [IDX_WIDTH-1:0]  best_index_o,
  output logic [WORD_WIDTH-1:0] best_value_o
);

  localparam int CNT_W = $clog2(MAX_COUNT + 1);

`ifdef SCAN_WRITEBACK_EN
  localparam state_e ST_AFTER_SCAN = ST_WRITE;
`else
  localparam state_e ST_AFTER_SCAN = ST_DONE;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [IDX_WIDTH-1:0]  i_q, i_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] base_q, cnt_addr_q;
  logic                  find_min_q;

  logic                  accept;
  logic [CNT_W-1:0]      n_clamped;
  logic                  last_entry;
  logic                  cmp_clear, cmp_sample, cmp_first;
  logic [ADDR_WIDTH-1:0] mem_address_c;
  logic                  mem_wr_en_c;
  logic [WORD_WIDTH-1:0] mem_wdata_c;
  logic [IDX_WIDTH-1:0]  best_index;
  logic [WORD_WIDTH-1:0] best_value;

  assign n_clamped  = (mem.mem_rdata > WORD_WIDTH'(MAX_COUNT)) ? CNT_W'(MAX_COUNT)
                                                               : CNT_W'(mem.mem_rdata);
  assign last_entry = (CNT_W'(i_q) == (n_q - CNT_W'(1)));

`ifdef SCAN_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] dest_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dest_q <= '0;
    end else if (accept) begin
      dest_q <= dest_addr_i;
    end
  end
`else
  logic unused_dest;
  assign unused_dest = ^dest_addr_i;
`endif

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    i_d           = i_q;
    valid_d       = valid_q;
    accept        = 1'b0;
    cmp_clear     = 1'b0;
    cmp_sample    = 1'b0;
    cmp_first     = 1'b0;
    mem_address_c = '0;
    mem_wr_en_c   = 1'b0;
    mem_wdata_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_RD_CNT;
        end
      end
      ST_RD_CNT: begin
        mem_address_c = cnt_addr_q;
        n_d           = n_clamped;
        i_d           = '0;
        if (n_clamped == '0) begin
          valid_d   = 1'b0;
          cmp_clear = 1'b1;
          state_d   = ST_AFTER_SCAN;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Entry address wraps modulo 2^ADDR_WIDTH.
        mem_address_c = base_q + ADDR_WIDTH'({i_q, 1'b0});
        cmp_sample    = 1'b1;
        cmp_first     = (i_q == '0);
        if (last_entry) begin
          valid_d = 1'b1;
          state_d = ST_AFTER_SCAN;
        end else begin
          i_d = i_q + IDX_WIDTH'(1);
        end
      end
`ifdef SCAN_WRITEBACK_EN
      ST_WRITE: begin
        mem_address_c = dest_q;
        mem_wr_en_c   = 1'b1;
        mem_wdata_c   = WORD_WIDTH'(best_index);
        state_d       = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      valid_q    <= 1'b0;
      base_q     <= '0;
      cnt_addr_q <= '0;
      find_min_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      valid_q <= valid_d;
      if (accept) begin
        base_q     <= base_addr_i;
        cnt_addr_q <= count_addr_i;
        find_min_q <= find_min_i;
      end
    end
  end

  mem_scan_cmp #(
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_cmp (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (cmp_clear),
    .sample_i     (cmp_sample),
    .first_i      (cmp_first),
    .find_min_i   (find_min_q),
    .index_i      (i_q),
    .data_i       (mem.mem_rdata),
    .best_index_o (best_index),
    .best_value_o (best_value)
  );

  assign mem.mem_address = mem_address_c;
  assign mem.mem_wr_en   = mem_wr_en_c;
  assign mem.mem_wdata   = mem_wdata_c;

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign valid_o      = valid_q;
  assign best_index_o = best_index;
  assign best_value_o = best_value;

endmodule

// File: tb/tb_mem_table_scan.sv
module tb_mem_table_scan;

`ifdef SCAN_WRITEBACK_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic        find_min;
  logic [15:0] base_addr;
  logic [15:0] count_addr;
  logic [15:0] dest_addr;
  logic        busy;
  logic        done;
  logic        valid;
  logic [5:0]  best_index;
  logic [15:0] best_value;

  logic        tb_we;
  logic [15:0] tb_addr;
  logic [15:0] tb_data;

  int n_vec = 0;
  int n_mis = 0;

  mem_table_scan_if mif();

  mem_table_scan dut (
    .clock        (clock),
    .reset        (reset),
    .start_i      (start),
    .find_min_i   (find_min),
    .base_addr_i  (base_addr),
    .count_addr_i (count_addr),
    .dest_addr_i  (dest_addr),
    .mem          (mif),
    .busy_o       (busy),
    .done_o       (done),
    .valid_o      (valid),
    .best_index_o (best_index),
    .best_value_o (best_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Byte-wide, big-endian data memory: combinational read, posedge write.
  logic [7:0]  mem_b [0:65535];
  logic [15:0] rd_p1;
  assign rd_p1         = mif.mem_address + 16'd1;
  assign mif.mem_rdata = {mem_b[mif.mem_address], mem_b[rd_p1]};

  always @(posedge clock) begin
    if (mif.mem_wr_en) begin
      mem_b[mif.mem_address]         <= mif.mem_wdata[15:8];
      mem_b[mif.mem_address + 16'd1] <= mif.mem_wdata[7:0];
    end else if (tb_we) begin
      mem_b[tb_addr]         <= tb_data[15:8];
      mem_b[tb_addr + 16'd1] <= tb_data[7:0];
    end
  end

  function automatic logic [15:0] rd_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem_b[a], mem_b[a1]};
  endfunction

  typedef struct {
    logic [15:0] cnt_addr;
    logic [15:0] cnt_word;
    logic [15:0] base;
    logic        find_min;
    int          kind;      // 0: 16-i x16, 1: v0..v3 list, 2: i x100
    logic [15:0] v0, v1, v2, v3;
    int          exp_idx;
    logic [15:0] exp_val;
    logic        exp_valid;
    int          exp_lat;   // done cycle without writeback
    int          exp_reads;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] val;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    tb_we   = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(posedge clock);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic preload(input vec_t v);
    logic [15:0] vals [4];
    vals[0] = v.v0; vals[1] = v.v1; vals[2] = v.v2; vals[3] = v.v3;
    wr_word(v.cnt_addr, v.cnt_word);
    case (v.kind)
      0: for (int i = 0; i < 16; i++) wr_word(v.base + 16'(2 * i), 16'(16 - i));
      1: for (int i = 0; i < int'(v.cnt_word) && i < 4; i++) wr_word(v.base + 16'(2 * i), vals[i]);
      default: for (int i = 0; i < 100; i++) wr_word(v.base + 16'(2 * i), 16'(i));
    endcase
  endtask

  task automatic set_inputs(input vec_t v);
    find_min   = v.find_min;
    base_addr  = v.base;
    count_addr = v.cnt_addr;
    dest_addr  = 16'h0700;
  endtask

  task automatic run_vector(input vec_t v, input int k);
    exp_t        e, got;
    int          cyc;
    int          busy_cnt;
    logic [15:0] alog[$];
    preload(v);
    set_inputs(v);
    e.idx   = v.exp_idx;
    e.val   = v.exp_val;
    e.valid = v.exp_valid;
    exp_q.push_back(e);
    start = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (1) begin
      if (busy) busy_cnt++;
      if (busy && !done && !mif.mem_wr_en) alog.push_back(mif.mem_address);
      if (done || cyc >= 300) break;
      @(posedge clock);
      #1;
      cyc++;
    end
    chk($sformatf("v%0d_done_seen", k), done, 1);
    chk($sformatf("v%0d_done_cycle", k), cyc, v.exp_lat + WB);
    got.idx   = best_index;
    got.val   = best_value;
    got.valid = valid;
    e = exp_q.pop_front();
    chk($sformatf("v%0d_best_index", k), got.idx, e.idx);
    chk($sformatf("v%0d_best_value", k), got.val, e.val);
    chk($sformatf("v%0d_valid", k), got.valid, e.valid);
    chk($sformatf("v%0d_busy_cycles", k), busy_cnt, v.exp_lat + WB);
    chk($sformatf("v%0d_table_reads", k), alog.size() - 1, v.exp_reads);
    chk($sformatf("v%0d_count_addr", k), alog[0], v.cnt_addr);
    if (v.exp_reads >= 2)
      chk($sformatf("v%0d_entry1_addr", k), alog[2], 16'(v.base + 16'd2));
    @(posedge clock);
    #1;
    chk($sformatf("v%0d_busy_after", k), busy, 0);
    chk($sformatf("v%0d_done_after", k), done, 0);
    chk($sformatf("v%0d_hold_value", k), best_value, e.val);
  endtask

  initial begin
    logic [15:0] keep_700;
    reset = 1'b1; start = 1'b0; find_min = 1'b0;
    base_addr = '0; count_addr = '0; dest_addr = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;

    //          cnt_addr  cnt    base      min kind v0       v1       v2     v3     idx val      vld lat reads
    vecs[0] = '{16'h0688, 16'd16,  16'h01C8, 0, 0, 16'd0,   16'd0,   16'd0, 16'd0, 0,  16'd16,   1, 18, 16};
    vecs[1] = '{16'h0688, 16'd16,  16'h01C8, 1, 0, 16'd0,   16'd0,   16'd0, 16'd0, 15, 16'd1,    1, 18, 16};
    vecs[2] = '{16'h068C, 16'd0,   16'h01C8, 0, 1, 16'd0,   16'd0,   16'd0, 16'd0, 0,  16'd0,    0, 2,  0};
    vecs[3] = '{16'h0688, 16'd4,   16'h0148, 0, 1, 16'd5,   16'd9,   16'd9, 16'd2, 1,  16'd9,    1, 6,  4};
    vecs[4] = '{16'h0688, 16'd3,   16'h0028, 1, 1, 16'd3,   16'd1,   16'd1, 16'd0, 1,  16'd1,    1, 5,  3};
    vecs[5] = '{16'h0688, 16'd100, 16'h0008, 0, 2, 16'd0,   16'd0,   16'd0, 16'd0, 63, 16'd63,   1, 66, 64};
    vecs[6] = '{16'h0688, 16'd2,   16'hFFFE, 0, 1, 16'd7,   16'h1234, 16'd0, 16'd0, 1, 16'h1234, 1, 4,  2};
    vecs[7] = '{16'h0688, 16'd3,   16'h0148, 1, 1, 16'd4,   16'd4,   16'd4, 16'd0, 0,  16'd4,    1, 5,  3};
    vecs[8] = '{16'h0688, 16'd2,   16'h01C8, 0, 1, 16'd1,   16'hFFFF, 16'd0, 16'd0, 1, 16'hFFFF, 1, 4,  2};
    vecs[9] = '{16'h0688, 16'd2,   16'h01C8, 1, 1, 16'h8000, 16'h7FFF, 16'd0, 16'd0, 1, 16'h7FFF, 1, 4, 2};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_best_index", best_index, 0);
    chk("rst_best_value", best_value, 0);
    chk("rst_mem_address", mif.mem_address, 0);
    chk("rst_mem_wr_en", mif.mem_wr_en, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int k = 0; k < 10; k++) begin
      run_vector(vecs[k], k);
`ifdef SCAN_WRITEBACK_EN
      if (k == 1) chk("wb_after_min16", rd_word(16'h0700), 16'h000F);
      if (k == 2) chk("wb_after_empty", rd_word(16'h0700), 16'h0000);
`endif
    end

    // Reset during cycle 5 of a scan aborts it cleanly.
    preload(vecs[0]);
    set_inputs(vecs[0]);
    keep_700 = rd_word(16'h0700);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_en", mif.mem_wr_en, 0);
    chk("abort_valid", valid, 0);
    chk("abort_best_index", best_index, 0);
    chk("abort_best_value", best_value, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_no_writeback", rd_word(16'h0700), keep_700);
    run_vector(vecs[0], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
